// File: rtl/jk_drive_sequencer.sv
// Command-driven j/k stimulus stage for a bank of JK flip-flops.
// Applies hold/reset/set/toggle to masked channels for N cycles and tracks the expected Q.
module jk_drive_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_mask,
  input  logic [CNT_W-1:0] cmd_count,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q_shadow
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  state_t           r_state, w_state_next;
  logic [1:0]       r_op, w_op_next;
  logic [WIDTH-1:0] r_mask, w_mask_next;
  logic [CNT_W-1:0] r_remaining, w_remaining_next;
  logic [WIDTH-1:0] r_j, r_k, r_q;
  logic [WIDTH-1:0] w_j_next, w_k_next, w_q_next;
  logic [WIDTH-1:0] w_drive_j, w_drive_k;
  logic [WIDTH-1:0] w_src_mask;
  logic [1:0]       w_src_op;
  logic             r_busy, r_done, r_ready;
  logic             w_busy_next, w_done_next, w_ready_next;
  logic             w_accept;

  assign w_accept   = cmd_valid & r_ready;
  // On the accepting edge the drive pattern comes straight from the command, later from the latch.
  assign w_src_mask = (r_state == S_IDLE) ? cmd_mask : r_mask;
  assign w_src_op   = (r_state == S_IDLE) ? cmd_op : r_op;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_chan
      assign w_drive_j[gi] = w_src_mask[gi] & w_src_op[1];
      assign w_drive_k[gi] = w_src_mask[gi] & w_src_op[0];
      // Same edge the downstream flop samples r_j/r_k: Q+ = J.~Q | ~K.Q
      assign w_q_next[gi]  = (r_j[gi] & ~r_q[gi]) | (~r_k[gi] & r_q[gi]);
    end
  endgenerate

  always_comb begin
    w_state_next     = r_state;
    w_op_next        = r_op;
    w_mask_next      = r_mask;
    w_remaining_next = r_remaining;
    w_j_next         = '0;
    w_k_next         = '0;
    w_busy_next      = 1'b0;
    w_done_next      = 1'b0;
    w_ready_next     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_next     = S_DRIVE;
          w_op_next        = cmd_op;
          w_mask_next      = cmd_mask;
          w_remaining_next = (cmd_count == '0) ? CNT_W'(1) : cmd_count;
          w_j_next         = w_drive_j;
          w_k_next         = w_drive_k;
          w_busy_next      = 1'b1;
        end else begin
          w_ready_next = 1'b1;
        end
      end
      S_DRIVE: begin
        w_remaining_next = r_remaining - CNT_W'(1);
        w_busy_next      = 1'b1;
        if (r_remaining == CNT_W'(1)) begin
          w_state_next = S_GAP;
          w_done_next  = 1'b1;
        end else begin
          w_j_next = w_drive_j;
          w_k_next = w_drive_k;
        end
      end
      S_GAP: begin
        w_state_next = S_IDLE;
        w_ready_next = 1'b1;
      end
      default: begin
        w_state_next = S_IDLE;
        w_ready_next = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_mask      <= '0;
      r_remaining <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_q         <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_op        <= w_op_next;
      r_mask      <= w_mask_next;
      r_remaining <= w_remaining_next;
      r_j         <= w_j_next;
      r_k         <= w_k_next;
      r_q         <= w_q_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
      r_ready     <= w_ready_next;
    end
  end

  assign cmd_ready = r_ready;
  assign j         = r_j;
  assign k         = r_k;
  assign busy      = r_busy;
  assign done      = r_done;
  assign q_shadow  = r_q;

endmodule

// File: tb/tb_jk_drive_sequencer.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic checked against a per-cycle schedule model.
module tb_jk_drive_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_mask;
  logic [7:0] cmd_count;
  logic [3:0] j, k, q_shadow;
  logic       busy, done;

  always #5 clk = ~clk;

  jk_drive_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_count(cmd_count),
    .j(j), .k(k), .busy(busy), .done(done), .q_shadow(q_shadow)
  );

  // Expected outputs for one cycle; the model keeps a queue of upcoming cycles.
  typedef struct packed {
    logic [3:0] j;
    logic [3:0] k;
    logic       busy;
    logic       done;
    logic       ready;
  } exp_t;

  typedef struct {
    logic [1:0] op;
    logic [3:0] mask;
    logic [7:0] count;
    int         exp_lat;
    logic [3:0] exp_q;
  } vec_t;

  localparam exp_t IDLE_REC = '{j: 4'b0, k: 4'b0, busy: 1'b0, done: 1'b0, ready: 1'b1};

  exp_t       sched[$];
  logic [3:0] exp_q;
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  bit         chk_en  = 0;
  bit         last_hs = 0;
  vec_t       vecs[7];

  function automatic logic [3:0] jk_apply(logic [3:0] q, logic [3:0] jj, logic [3:0] kk);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      case ({jj[i], kk[i]})
        2'b00:   r[i] = q[i];
        2'b01:   r[i] = 1'b0;
        2'b10:   r[i] = 1'b1;
        default: r[i] = ~q[i];
      endcase
    end
    return r;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Compare this cycle's outputs with the model, advance the model past the next edge.
  task automatic tick();
    exp_t cur;
    exp_t rec;
    int   n;
    cur = (sched.size() == 0) ? IDLE_REC : sched[0];
    if (chk_en) begin
      n_tests++;
      if (j !== cur.j || k !== cur.k || busy !== cur.busy || done !== cur.done ||
          cmd_ready !== cur.ready || q_shadow !== exp_q) begin
        n_fail++;
        $display("FAIL cycle%0d: got j=%b k=%b busy=%b done=%b rdy=%b q=%b, expected j=%b k=%b busy=%b done=%b rdy=%b q=%b",
                 cyc, j, k, busy, done, cmd_ready, q_shadow,
                 cur.j, cur.k, cur.busy, cur.done, cur.ready, exp_q);
      end
    end
    last_hs = 0;
    if (rst) begin
      sched.delete();
      exp_q = 4'b0;
    end else begin
      exp_q = jk_apply(exp_q, cur.j, cur.k);
      if (sched.size() > 0) void'(sched.pop_front());
      if (cmd_valid && cur.ready) begin
        last_hs = 1;
        n = (cmd_count == 0) ? 1 : int'(cmd_count);
        $display("[TB] cycle %0d cmd op=%b mask=%b count=%0d", cyc, cmd_op, cmd_mask, cmd_count);
        rec = '{j: cmd_mask & {4{cmd_op[1]}}, k: cmd_mask & {4{cmd_op[0]}},
                busy: 1'b1, done: 1'b0, ready: 1'b0};
        for (int i = 0; i < n; i++) sched.push_back(rec);
        rec = '{j: 4'b0, k: 4'b0, busy: 1'b1, done: 1'b1, ready: 1'b0};
        sched.push_back(rec);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_cmd(input vec_t v);
    int lat;
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_mask  = v.mask;
    cmd_count = v.count;
    tick();
    check("handshake", 32'(last_hs), 32'd1);
    cmd_valid = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
    check("done_latency", 32'(lat), 32'(v.exp_lat));
    check("q_at_done", 32'(q_shadow), 32'(v.exp_q));
    tick();
    check("ready_after", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int c0, c1;
    vecs[0] = '{op: 2'b11, mask: 4'b1010, count: 8'd3,   exp_lat: 4,   exp_q: 4'b1010};
    vecs[1] = '{op: 2'b10, mask: 4'b1111, count: 8'd0,   exp_lat: 2,   exp_q: 4'b1111};
    vecs[2] = '{op: 2'b01, mask: 4'b0011, count: 8'd2,   exp_lat: 3,   exp_q: 4'b1100};
    vecs[3] = '{op: 2'b00, mask: 4'b1111, count: 8'd4,   exp_lat: 5,   exp_q: 4'b1100};
    vecs[4] = '{op: 2'b11, mask: 4'b0000, count: 8'd2,   exp_lat: 3,   exp_q: 4'b1100};
    vecs[5] = '{op: 2'b11, mask: 4'b0001, count: 8'd255, exp_lat: 256, exp_q: 4'b1101};
    vecs[6] = '{op: 2'b11, mask: 4'b0110, count: 8'd2,   exp_lat: 3,   exp_q: 4'b1101};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b0; cmd_mask = 4'b0; cmd_count = 8'd0;
    exp_q = 4'b0;
    tick();
    chk_en = 1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("idle_ready", 32'(cmd_ready), 32'd1);
    check("idle_q", 32'(q_shadow), 32'd0);

    foreach (vecs[i]) run_cmd(vecs[i]);

    // Valid held high with changing data: second handshake exactly N+2 cycles later.
    c0 = -1; c1 = -1;
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_mask = 4'b0001; cmd_count = 8'd2;
    for (int i = 0; i < 12 && c1 < 0; i++) begin
      tick();
      if (last_hs) begin
        if (c0 < 0) c0 = cyc;
        else c1 = cyc;
      end
      if (c1 < 0 && c0 >= 0) begin
        cmd_op    = 2'($urandom);
        cmd_mask  = 4'($urandom);
        cmd_count = 8'($urandom_range(1, 9));
      end
    end
    cmd_valid = 1'b0;
    check("hold_spacing", 32'(c1 - c0), 32'd4);
    for (int i = 0; i < 12; i++) tick();

    // Reset in the second drive cycle of a count=5 toggle.
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_mask = 4'b1111; cmd_count = 8'd5;
    tick();
    check("abort_hs", 32'(last_hs), 32'd1);
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_j", 32'(j), 32'd0);
    check("abort_k", 32'(k), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_q", 32'(q_shadow), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      check("abort_no_done", 32'(done), 32'd0);
      tick();
    end

    // Randomized traffic against the schedule model.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(99) == 0);
      cmd_valid = 1'($urandom_range(1));
      cmd_op    = 2'($urandom);
      cmd_mask  = 4'($urandom);
      cmd_count = ($urandom_range(7) == 0) ? 8'($urandom_range(30)) : 8'($urandom_range(4));
      tick();
    end
    rst = 1'b0; cmd_valid = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_drive_sequencer.md
Name: jk_drive_sequencer

Overview:
- Command-driven stimulus stage placed directly upstream of a bank of WIDTH JK flip-flops, one per channel. Drives each flip-flop's j/k pair.
- Accepts one command at a time over a valid/ready handshake. Each command carries an op (hold/reset/set/toggle), a channel mask and a repeat count. The block applies the op for that many clock cycles, then reports completion.
- Keeps a shadow copy of the expected flip-flop outputs so the downstream bank can be checked cycle by cycle.

Parameters:
- WIDTH, 4, number of JK channels driven.
- CNT_W, 8, width of the repeat-count field.

Ports:
- clk  input  1  rising-edge clock, shared with the downstream JK bank.
- rst  input  1  synchronous active-high reset, shared with the downstream JK bank.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_op  input  2  op encoding, identical to the {j,k} encoding: 00 hold, 01 reset, 10 set, 11 toggle.
- cmd_mask  input  WIDTH  channels the op applies to; unmasked channels get j=k=0.
- cmd_count  input  CNT_W  number of drive cycles; 0 is treated as 1.
- j  output  WIDTH  per-channel J drive, registered.
- k  output  WIDTH  per-channel K drive, registered.
- busy  output  1  high in DRIVE and GAP.
- done  output  1  one-cycle pulse in GAP after the last drive cycle.
- q_shadow  output  WIDTH  expected Q of each downstream flip-flop.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; j=0, k=0, busy=0, done=0, q_shadow=0, cmd_ready=1 in the following cycle.
  - Reset overrides everything, including mid-DRIVE or mid-GAP; an in-flight command is discarded.
  - q_shadow=0 matches the downstream flip-flop reset value Q=0.
- States: IDLE, DRIVE, GAP.
- IDLE:
  - cmd_ready=1, j=k=0, busy=0.
  - Handshake fires when cmd_valid=1 and cmd_ready=1 at an edge (cycle t).
  - On that edge: latch op and mask; load remaining=max(cmd_count,1); go to DRIVE.
- DRIVE:
  - Occupies cycles t+1 .. t+N, where N=max(cmd_count,1).
  - cmd_ready=0, busy=1.
  - For each channel i with mask[i]=1: {j[i],k[i]}=op. For each unmasked channel: j[i]=k[i]=0.
  - remaining decrements at each edge. At the edge ending cycle t+N: go to GAP and drive j=k=0.
- GAP:
  - Lasts exactly one cycle (t+N+1): done=1, busy=1, cmd_ready=0, j=k=0.
  - Next edge: go to IDLE; cmd_ready=1 from cycle t+N+2.
  - Minimum command-to-command spacing is N+2 cycles.
- q_shadow:
  - Updates at the same edges at which the downstream flip-flops sample j/k, using JK rules per bit on the currently driven j/k: 00 hold, 01 clear, 10 set, 11 invert.
  - In cycle t+N+1, q_shadow equals the downstream Q after the final drive edge.
- Op 00 (hold) still consumes N drive cycles and produces a done pulse.
- A mask of all zeros behaves like op 00.
- cmd_count = 2^CNT_W − 1 must run the full count with no wrap; remaining never underflows.
- While cmd_ready=0, cmd_valid and all cmd_* inputs are ignored; the upstream source must hold them.
- All outputs are registered; there is no combinational path from cmd_* to j/k.

Test Plan:
- Reset then idle, no command → j=k=0, q_shadow=0, cmd_ready=1, busy=0 indefinitely.
- Command op=11, mask=4'b1010, count=3 from q=0 → j=k=4'b1010 for cycles t+1..t+3; done at t+4; q_shadow=4'b1010; cmd_ready=1 at t+5.
- Command op=10, mask=4'b1111, count=0 → exactly 1 drive cycle (j=4'b1111, k=0); done at t+2; q_shadow=4'b1111. Follow with op=01, mask=4'b0011, count=2 → q_shadow=4'b1100.
- cmd_valid held high with changing data during DRIVE → only the first command executes; a second handshake occurs exactly at t+N+2.
- rst asserted in the 2nd cycle of a count=5 toggle command → next cycle j=k=0, busy=0, done=0, q_shadow=0, cmd_ready=1; no done pulse ever appears for the aborted command.
- count=255, op=11, mask=4'b0001 → 255 drive cycles, done at t+256; q_shadow=4'b0001 (odd number of toggles).
